uart_tx_buf: RTL and testbench

Byte-buffering front end placed directly upstream of the UART byte transmitter. Producer logic writes bytes into an internal FIFO at any rate. The block drains the FIFO one byte at a time: it issues a single-cycle `uart_tx_en` with the byte on `uart_tx_data`, waits for the transmitter's `uart_tx_done`, then optionally holds an inter-byte gap. The block never pulses `uart_tx_en` while a frame is in flight, because the transmitter restarts on any `uart_tx_en`.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_buf_if.sv | 48 ++++
 rtl/uart_sync_fifo.sv | 65 ++++++
 rtl/uart_tx_buf.sv | 101 ++++++++++
 tb/tb_uart_tx_buf.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// FSM encoding and frame geometry live here.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } tx_state_e;

  function automatic int lvl_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Producer / transmitter bundle for uart_tx_buf.
// The master side writes bytes and answers with uart_tx_done.
interface uart_tx_buf_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
);

  localparam int LW = lvl_bits(FIFO_DEPTH);

  logic                      wr_en;
  logic [UART_DATA_BITS-1:0] wr_data;
  logic                      wr_full;
  logic                      wr_empty;
  logic [LW-1:0]             fifo_level;
  logic                      overflow;
  logic                      tx_busy;
  logic                      uart_tx_en;
  logic [UART_DATA_BITS-1:0] uart_tx_data;
  logic                      uart_tx_done;

  modport master (
    output wr_en,
    output wr_data,
    output uart_tx_done,
    input  wr_full,
    input  wr_empty,
    input  fifo_level,
    input  overflow,
    input  tx_busy,
    input  uart_tx_en,
    input  uart_tx_data
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  uart_tx_done,
    output wr_full,
    output wr_empty,
    output fifo_level,
    output overflow,
    output tx_busy,
    output uart_tx_en,
    output uart_tx_data
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level flags.
// Pointers carry one extra wrap bit to separate full from empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [lvl_bits(DEPTH)-1:0] level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_n;
  logic [AW:0]      rd_ptr_n;
  logic             push_ok;
  logic             pop_ok;
  logic             full_n;

  // A full FIFO rejects writes even when a pop lands on the same edge.
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign wr_ptr_n = wr_ptr + (AW+1)'(push_ok);
  assign rd_ptr_n = rd_ptr + (AW+1)'(pop_ok);
  assign full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW])
                 && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      full     <= full_n;
      empty    <= (wr_ptr_n == rd_ptr_n);
      level    <= wr_ptr_n - rd_ptr_n;
      overflow <= overflow || (push && full);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Byte buffer in front of the UART transmitter: queues bytes
// and launches them one frame at a time with an optional gap.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  uart_tx_buf_if.slave bus
);

  localparam int LW = lvl_bits(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_e                 state;
  logic [GW-1:0]             gap_cnt;
  logic [UART_DATA_BITS-1:0] head;
  logic                      pop;
  logic                      push_ok;
  logic                      empty_nxt;

  assign pop     = (state == ST_IDLE) && !bus.wr_empty;
  assign push_ok = bus.wr_en && !bus.wr_full;

  // Emptiness after this edge, so tx_busy carries no extra lag.
  assign empty_nxt = bus.wr_empty ? !push_ok
                   : (bus.fifo_level == LW'(1)) && pop && !push_ok;

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .head      (head),
    .full      (bus.wr_full),
    .empty     (bus.wr_empty),
    .level     (bus.fifo_level),
    .overflow  (bus.overflow)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= ST_IDLE;
      gap_cnt          <= '0;
      bus.uart_tx_en   <= 1'b0;
      bus.uart_tx_data <= '0;
      bus.tx_busy      <= 1'b0;
    end else begin
      bus.uart_tx_en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            state            <= ST_LAUNCH;
            bus.uart_tx_en   <= 1'b1;
            bus.uart_tx_data <= head;
            bus.tx_busy      <= 1'b1;
          end else begin
            bus.tx_busy <= !empty_nxt;
          end
        end
        ST_LAUNCH: begin
          state       <= ST_WAIT_DONE;
          bus.tx_busy <= 1'b1;
        end
        ST_WAIT_DONE: begin
          if (bus.uart_tx_done && (GAP_CYCLES > 0)) begin
            state       <= ST_GAP;
            gap_cnt     <= '0;
            bus.tx_busy <= 1'b1;
          end else if (bus.uart_tx_done) begin
            state       <= ST_IDLE;
            bus.tx_busy <= !empty_nxt;
          end else begin
            bus.tx_busy <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state       <= ST_IDLE;
            bus.tx_busy <= !empty_nxt;
          end else begin
            gap_cnt     <= gap_cnt + 1'b1;
            bus.tx_busy <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: queue-level reference model,
// transmitter responder and a directed gap-timing check.
module tb_uart_tx_buf;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  always #5 sys_clk = ~sys_clk;

  uart_tx_buf_if #(.FIFO_DEPTH(DEPTH)) bus ();
  uart_tx_buf_if #(.FIFO_DEPTH(DEPTH)) bus5 ();

  uart_tx_buf #(
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (0)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  uart_tx_buf #(
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (5)
  ) dut5 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus5)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  // Reference model: byte queue plus "transmitter free" flag.
  logic [7:0] exp_q[$];
  int m_level  = 0;
  bit m_ready  = 1'b1;
  int m_infl   = 0;
  bit m_ovf    = 1'b0;
  bit m_en     = 1'b0;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_level = 0;
      m_ready = 1'b1;
      m_infl  = 0;
      m_ovf   = 1'b0;
      m_en    = 1'b0;
      exp_q.delete();
    end else begin
      bit launch;
      bit acc;
      launch = m_ready && (m_level > 0);
      acc    = bus.wr_en && (m_level < DEPTH);
      if (bus.wr_en && !acc) m_ovf = 1'b1;
      if (acc) exp_q.push_back(bus.wr_data);
      m_level = m_level + int'(acc) - int'(launch);
      if (m_infl == 1 && bus.uart_tx_done) begin
        m_infl  = 0;
        m_ready = 1'b1;
      end else if (m_infl == 2) begin
        m_infl = 1;
      end
      if (launch) begin
        m_ready = 1'b0;
        m_infl  = 2;
      end
      m_en = launch;
    end
  end

  // Monitor and transmitter responder.
  logic [7:0] last_data = 8'h00;
  bit   xm_busy   = 1'b0;
  int   xm_cnt    = 0;
  bit   stall     = 1'b0;
  logic xm_done   = 1'b0;
  logic spur_done = 1'b0;

  assign bus.uart_tx_done = xm_done | spur_done;

  always @(negedge sys_clk) begin
    xm_done = 1'b0;
    if (!sys_rst_n) begin
      xm_busy   = 1'b0;
      last_data = 8'h00;
    end else begin
      chk("level", bus.fifo_level, m_level);
      chk("full", bus.wr_full, m_level == DEPTH);
      chk("empty", bus.wr_empty, m_level == 0);
      chk("overflow", bus.overflow, m_ovf);
      chk("busy", bus.tx_busy, !m_ready || m_level > 0);
      chk("tx_en", bus.uart_tx_en, m_en);
      if (bus.uart_tx_en) begin
        chk("en_in_flight", xm_busy, 1'b0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL launch_q: launch with no queued byte t=%0t",
                   $time);
        end else begin
          last_data = exp_q.pop_front();
        end
        xm_busy = 1'b1;
        xm_cnt  = $urandom_range(1, 6);
      end else if (xm_busy && !stall) begin
        if (xm_cnt == 0) begin
          xm_done = 1'b1;
          xm_busy = 1'b0;
        end else begin
          xm_cnt--;
        end
      end
      chk("tx_data", bus.uart_tx_data, last_data);
    end
  end

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (m_level == 0 && m_ready && !xm_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout waiting for idle", nm);
    end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_en"}, bus.uart_tx_en, 1'b0);
    chk({nm, "_data"}, bus.uart_tx_data, 8'h00);
    chk({nm, "_full"}, bus.wr_full, 1'b0);
    chk({nm, "_empty"}, bus.wr_empty, 1'b1);
    chk({nm, "_level"}, bus.fifo_level, 0);
    chk({nm, "_ovf"}, bus.overflow, 1'b0);
    chk({nm, "_busy"}, bus.tx_busy, 1'b0);
  endtask

  task automatic burst(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      bus.wr_en   = 1'b1;
      bus.wr_data = base + 8'(i);
    end
    @(negedge sys_clk);
    bus.wr_en = 1'b0;
  endtask

  // GAP_CYCLES=5 instance: launch spacing and tx_busy fall.
  task automatic gap_test();
    int k;
    @(negedge sys_clk);
    bus5.wr_en   = 1'b1;
    bus5.wr_data = 8'h3C;
    @(negedge sys_clk);
    bus5.wr_data = 8'hC3;
    @(negedge sys_clk);
    bus5.wr_en = 1'b0;
    chk("gap_en1", bus5.uart_tx_en, 1'b1);
    chk("gap_data1", bus5.uart_tx_data, 8'h3C);
    repeat (3) @(negedge sys_clk);
    bus5.uart_tx_done = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge sys_clk);
      bus5.uart_tx_done = 1'b0;
      if (bus5.uart_tx_en) begin
        k = i;
        break;
      end
    end
    chk("gap_spacing", k, 7);
    chk("gap_data2", bus5.uart_tx_data, 8'hC3);
    repeat (2) @(negedge sys_clk);
    bus5.uart_tx_done = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge sys_clk);
      bus5.uart_tx_done = 1'b0;
      if (!bus5.tx_busy) begin
        k = i;
        break;
      end
    end
    chk("gap_busy_fall", k, 6);
  endtask

  initial begin
    bus.wr_en         = 1'b0;
    bus.wr_data       = 8'h00;
    bus5.wr_en        = 1'b0;
    bus5.wr_data      = 8'h00;
    bus5.uart_tx_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_reset("rst");
    #2 sys_rst_n = 1'b1;

    gap_test();

    burst(1, 8'hA5);
    wait_idle("single");
    chk("single_data", bus.uart_tx_data, 8'hA5);
    chk("single_empty", bus.wr_empty, 1'b1);
    chk("single_busy", bus.tx_busy, 1'b0);

    burst(5, 8'h01);
    wait_idle("burst");
    chk("burst_last", bus.uart_tx_data, 8'h05);

    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      bus.wr_en   = ($urandom_range(0, 99) < 35);
      bus.wr_data = 8'($urandom);
    end
    @(negedge sys_clk);
    bus.wr_en = 1'b0;
    wait_idle("random");

    stall = 1'b1;
    burst(18, 8'h40);
    chk("ovf_full", bus.wr_full, 1'b1);
    chk("ovf_flag", bus.overflow, 1'b1);
    chk("ovf_level", bus.fifo_level, DEPTH);
    stall = 1'b0;
    wait_idle("overflow");
    chk("ovf_last", bus.uart_tx_data, 8'h50);

    @(negedge sys_clk);
    spur_done = 1'b1;
    @(negedge sys_clk);
    spur_done = 1'b0;
    repeat (5) @(negedge sys_clk);
    chk("spur_busy", bus.tx_busy, 1'b0);

    stall = 1'b1;
    burst(4, 8'h90);
    repeat (3) @(negedge sys_clk);
    chk("mid_level", bus.fifo_level, 3);
    #2 sys_rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    stall = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("post_rst_busy", bus.tx_busy, 1'b0);
    burst(1, 8'h77);
    wait_idle("post_rst");
    chk("post_rst_data", bus.uart_tx_data, 8'h77);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
